// File: rtl/seq_mult_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier:
// FSM state encoding and default width constants.
package seq_mult_unit_pkg;

  // Default operand width and matching iteration counter width
  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  // Controller states: accept -> iterate over multiplier bits -> sign fix-up
  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_CALC = 2'd1,
    MULT_FIX  = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_mult_unit_adder.sv
// Plain W-bit adder used on the accumulate path of the multiplier.
// The carry out of the top bit is intentionally dropped (modulo 2^W sum).
module seq_mult_unit_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier
// bit per clock. Operands are reduced to magnitudes on accept and the sign
// is re-applied in a single FIX cycle, so the datapath is purely unsigned.
// Optional build macro MULT_EARLY_TERM_EN: leave CALC as soon as the
// remaining multiplier bits are all zero (result is unchanged).
module seq_mult_unit
  import seq_mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_e       r_state;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [PW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg;
  logic              r_busy;
  logic              r_done;
  logic [PW-1:0]     r_prod;

  logic [WIDTH-1:0]  w_abs_a;
  logic [WIDTH-1:0]  w_abs_b;
  logic              w_neg_sel;
  logic [PW-1:0]     w_addend;
  logic [PW-1:0]     w_sum;
  logic [PW-1:0]     w_neg_acc;
  logic [WIDTH-1:0]  w_mplier_shr;
  logic              w_last;

  // Operand magnitudes and result sign for the op being accepted; the most
  // negative value maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits
  always_comb begin
    w_abs_a   = srca;
    w_abs_b   = srcb;
    w_neg_sel = 1'b0;
    if (is_signed) begin
      w_neg_sel = srca[WIDTH-1] ^ srcb[WIDTH-1];
      if (srca[WIDTH-1]) begin
        w_abs_a = ~srca + ONE_W;
      end else begin
        w_abs_a = srca;
      end
      if (srcb[WIDTH-1]) begin
        w_abs_b = ~srcb + ONE_W;
      end else begin
        w_abs_b = srcb;
      end
    end else begin
      w_neg_sel = 1'b0;
    end
  end

  // Partial product for this iteration: multiplicand shifted to the bit position
  always_comb begin
    w_addend = {PW{1'b0}};
    if (r_mplier[0]) begin
      w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    end else begin
      w_addend = {PW{1'b0}};
    end
  end

  seq_mult_unit_adder #(.W(PW)) u_acc_adder (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .o_sum (w_sum)
  );

  assign w_neg_acc    = ~r_acc + ONE_P;
  assign w_mplier_shr = {1'b0, r_mplier[WIDTH-1:1]};

  // Decide whether the current CALC edge is the final iteration
  always_comb begin
    w_last = 1'b0;
`ifdef MULT_EARLY_TERM_EN
    if ((r_cnt == CNT_LAST) || (w_mplier_shr == {WIDTH{1'b0}})) begin
      w_last = 1'b1;
    end else begin
      w_last = 1'b0;
    end
`else
    if (r_cnt == CNT_LAST) begin
      w_last = 1'b1;
    end else begin
      w_last = 1'b0;
    end
`endif
  end

  // Controller and datapath registers: accept, iterate, apply sign, report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MULT_IDLE;
      r_mcand  <= {WIDTH{1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_acc    <= {PW{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_prod   <= {PW{1'b0}};
    end else begin
      case (r_state)
        MULT_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_neg    <= w_neg_sel;
            r_acc    <= {PW{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= MULT_CALC;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        MULT_CALC: begin
          r_done   <= 1'b0;
          r_acc    <= w_sum;
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_state <= MULT_FIX;
          end else begin
            r_state <= MULT_CALC;
          end
        end
        MULT_FIX: begin
          if (r_neg) begin
            r_prod <= w_neg_acc;
          end else begin
            r_prod <= r_acc;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= MULT_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= MULT_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign prod = r_prod;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Self-checking bench for seq_mult_unit: directed vector table, handshake
// corner sequences, and random signed/unsigned regression at WIDTH 8 and 32.
module tb_seq_mult_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        start32, sg32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult_unit #(.WIDTH(8), .CNT_W(6)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
    .srca(a8), .srcb(b8), .busy(busy8), .done(done8), .prod(prod8));

  seq_mult_unit #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sg32),
    .srca(a32), .srcb(b32), .busy(busy32), .done(done32), .prod(prod32));

  typedef struct {
    bit          s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat_fix;
    int          lat_et;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_w(input int w);
    if (w >= 64) return {64{1'b1}};
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference product: sign-extend to 64 bits, multiply, keep 2w bits
  function automatic logic [63:0] ref_prod(input int w, input bit s,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = a & mask_w(w);
    eb = b & mask_w(w);
    if (s && ea[w-1]) ea = ea | ~mask_w(w);
    if (s && eb[w-1]) eb = eb | ~mask_w(w);
    return (ea * eb) & mask_w(2 * w);
  endfunction

  // Reference latency in edges from accept to done
  function automatic int ref_lat(input int w, input bit s, input logic [63:0] b);
    logic [63:0] mag;
    int hi;
    mag = b & mask_w(w);
    if (s && mag[w-1]) mag = (~mag + 64'd1) & mask_w(w);
    hi = -1;
    for (int i = 0; i < w; i++) if (mag[i]) hi = i;
`ifdef MULT_EARLY_TERM_EN
    return (hi < 0) ? 2 : hi + 2;
`else
    return (hi < -1) ? 0 : w + 1;
`endif
  endfunction

  task automatic drive(input int w, input bit st, input bit s,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 8) begin
      start8 = st; sg8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; sg32 = s; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done32;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy32;
  endfunction

  function automatic logic [63:0] get_prod(input int w);
    return (w == 8) ? {48'd0, prod8} : prod32;
  endfunction

  // One full operation: accept, scramble inputs, wait (bounded) for done
  task automatic run_op(input int w, input bit s, input logic [63:0] a,
                        input logic [63:0] b, output int lat, output logic [63:0] p);
    lat = -1;
    p   = '0;
    drive(w, 1'b1, s, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, ~s, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    check("busy_after_accept", {63'd0, get_busy(w)}, 64'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (get_done(w)) begin
        lat = k;
        p   = get_prod(w);
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done, required done within 40 edges");
    end else begin
      check("busy_at_done", {63'd0, get_busy(w)}, 64'd0);
      @(posedge clk); #1;
      check("done_one_cycle", {63'd0, get_done(w)}, 64'd0);
      check("prod_held", get_prod(w), p);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    int          lat, lat2, ndone, exp_lat;
    logic [63:0] p, p2, a, b;
    bit          s, held_ok;

    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 9, 9};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 9, 9};
    vecs[2] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 9, 4};
    vecs[3] = '{1'b0, 8'hFD, 8'h05, 16'h04F1, 9, 4};
    vecs[4] = '{1'b0, 8'h0A, 8'h0B, 16'h006E, 9, 5};
    vecs[5] = '{1'b0, 8'h7F, 8'h02, 16'h00FE, 9, 3};
    vecs[6] = '{1'b0, 8'h33, 8'h00, 16'h0000, 9, 2};
    vecs[7] = '{1'b1, 8'h7F, 8'h80, 16'hC080, 9, 9};
    vecs[8] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 9, 2};

    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    #22;
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_done8", {63'd0, done8}, 64'd0);
    check("rst_prod8", {48'd0, prod8}, 64'd0);
    check("rst_prod32", prod32, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      run_op(8, vecs[i].s, {56'd0, vecs[i].a}, {56'd0, vecs[i].b}, lat, p);
      check($sformatf("vec%0d_prod", i), p, {48'd0, vecs[i].exp});
`ifdef MULT_EARLY_TERM_EN
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat_et));
`else
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat_fix));
`endif
    end

    // start pulses while busy are ignored
    drive(8, 1'b1, 1'b0, 64'h0B, 64'h0D);
    @(posedge clk); #1;
    ndone = 0; lat = -1; p = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2 || k == 4) drive(8, 1'b1, 1'b1, 64'hFF, 64'hFF);
      else drive(8, 1'b0, 1'b0, 64'h00, 64'h00);
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        lat = k;
        p = {48'd0, prod8};
      end
    end
    drive(8, 1'b0, 1'b0, 64'h00, 64'h00);
    check("busy_start_ndone", 64'(ndone), 64'd1);
    check("busy_start_prod", p, ref_prod(8, 1'b0, 64'h0B, 64'h0D));
    check("busy_start_lat", 64'(lat), 64'(ref_lat(8, 1'b0, 64'h0D)));

    // Back-to-back: new start in the done cycle
    drive(8, 1'b1, 1'b0, 64'h0C, 64'h0C);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 64'h00, 64'h00);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; break; end
    end
    check("b2b_first_prod", {48'd0, prod8}, 64'h0090);
    drive(8, 1'b1, 1'b0, 64'h0A, 64'h0B);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 64'h00, 64'h00);
    check("b2b_busy", {63'd0, busy8}, 64'd1);
    held_ok = 1'b1; lat2 = -1; p2 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat2 = k;
        p2 = {48'd0, prod8};
        break;
      end else if (prod8 !== 16'h0090) begin
        held_ok = 1'b0;
      end
    end
    check("b2b_prod_held", {63'd0, held_ok}, 64'd1);
    check("b2b_prod", p2, 64'h006E);
    check("b2b_lat", 64'(lat2), 64'(ref_lat(8, 1'b0, 64'h0B)));

    // Asynchronous reset mid-CALC
    drive(8, 1'b1, 1'b0, 64'hFF, 64'hFF);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 64'h00, 64'h00);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", {63'd0, busy8}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy8}, 64'd0);
    check("async_rst_done", {63'd0, done8}, 64'd0);
    check("async_rst_prod", {48'd0, prod8}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    check("no_done_after_rst", 64'(ndone), 64'd0);

    // Random regression, WIDTH=8
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = {56'd0, 8'($urandom())};
      b = {56'd0, 8'($urandom())};
      run_op(8, s, a, b, lat, p);
      check($sformatf("rnd8_%0d_prod", i), p, ref_prod(8, s, a, b));
      check($sformatf("rnd8_%0d_lat", i), 64'(lat), 64'(ref_lat(8, s, b)));
    end

    // Random regression, WIDTH=32
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = {32'd0, 32'($urandom())};
      b = {32'd0, 32'($urandom())};
      if (i % 8 == 0) a = 64'h0000_0000_8000_0000;
      if (i % 8 == 1) b = 64'h0000_0000_8000_0000;
      if (i % 8 == 2) b = 64'h0000_0000_0000_0000;
      if (i % 8 == 3) a = 64'h0000_0000_FFFF_FFFF;
      if (i % 8 == 4) b = {32'd0, 32'($urandom_range(0, 15))};
      run_op(32, s, a, b, lat, p);
      exp_lat = ref_lat(32, s, b);
      check($sformatf("rnd32_%0d_prod", i), p, ref_prod(32, s, a, b));
      check($sformatf("rnd32_%0d_lat", i), 64'(lat), 64'(exp_lat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
